// File: rtl/vrased_reset_ctrl.sv
// vrased_reset_ctrl: violation aggregator and reset sequencer for the VRASED monitors.
// Masks each monitor's reset request and drives a registered, stretched MCU reset pulse.
// Records the sticky cause, the first cause and a saturating event count.
// Optional feature: define VRASED_EVENT_LOG_EN to build the circular {pc, cause} event log.
// Without the macro, the log outputs are tied to zero.
module vrased_reset_ctrl #(
    parameter int unsigned NUM_SRC     = 6,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned LOG_DEPTH   = 8,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned IDX_W      = $clog2(LOG_DEPTH),
    localparam int unsigned REC_W      = 16 + NUM_SRC
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_viol,
    input  logic [NUM_SRC-1:0] i_src_mask,
    input  logic [15:0]        i_pc,
    output logic               o_reset,
    output logic [NUM_SRC-1:0] o_cause,
    output logic [NUM_SRC-1:0] o_first_cause,
    output logic [CNT_W-1:0]   o_viol_cnt,
    input  logic               i_re,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic [REC_W-1:0]   o_rd_data,
    output logic [IDX_W:0]     o_log_count,
    output logic               o_log_ovf,
    input  logic               i_clr_log
);

    // Hold counter must be able to hold HOLD_CYCLES-1.
    localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StDrain
    } state_e;

    state_e             r_state;
    logic [HC_W-1:0]    r_hold_cnt;
    logic               r_reset;

    logic [NUM_SRC-1:0] r_cause;
    logic [NUM_SRC-1:0] r_first_cause;
    logic [CNT_W-1:0]   r_viol_cnt;

    logic [NUM_SRC-1:0] w_hit_vec;
    logic               w_hit;
    logic               w_event;

    logic [NUM_SRC-1:0] w_cause_base;
    logic [NUM_SRC-1:0] w_first_base;
    logic [CNT_W-1:0]   w_cnt_base;

    // Only unmasked sources participate; masked ones never touch any state.
    assign w_hit_vec = i_viol & ~i_src_mask;
    assign w_hit     = |w_hit_vec;

    // Activity while the pulse is already running is folded into cause but is not an event.
    assign w_event   = (r_state == StIdle) && w_hit;

    // A clear in the same cycle as an event applies first, so the event sees zeroed state.
    assign w_cause_base = i_clr_log ? '0 : r_cause;
    assign w_first_base = i_clr_log ? '0 : r_first_cause;
    assign w_cnt_base   = i_clr_log ? '0 : r_viol_cnt;

    // Reset pulse sequencer: HOLD covers HOLD_CYCLES-1 cycles and DRAIN supplies the last one,
    // so a single-cycle violation gives exactly HOLD_CYCLES cycles of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_hold_cnt <= '0;
            r_reset    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_hit) begin
                        r_reset <= 1'b1;
                        if (HOLD_CYCLES > 1) begin
                            r_state    <= StHold;
                            r_hold_cnt <= HC_LOAD;
                        end else begin
                            r_state    <= StDrain;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                StHold: begin
                    r_reset <= 1'b1;
                    if (r_hold_cnt <= HC_ONE) begin
                        r_state    <= StDrain;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HC_ONE;
                    end
                end
                StDrain: begin
                    if (!w_hit) begin
                        r_state <= StIdle;
                        r_reset <= 1'b0;
                    end else begin
                        r_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_hold_cnt <= '0;
                    r_reset    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky cause, first cause and saturating event counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cause       <= '0;
            r_first_cause <= '0;
            r_viol_cnt    <= '0;
        end else begin
            r_cause       <= w_cause_base | w_hit_vec;
            r_first_cause <= w_first_base;
            r_viol_cnt    <= w_cnt_base;
            if (w_event) begin
                if (!(&w_cnt_base)) begin
                    r_viol_cnt <= w_cnt_base + CNT_W'(1);
                end
                if (w_cnt_base == '0) begin
                    r_first_cause <= w_hit_vec;
                end
            end
        end
    end

    assign o_reset       = r_reset;
    assign o_cause       = r_cause;
    assign o_first_cause = r_first_cause;
    assign o_viol_cnt    = r_viol_cnt;

`ifdef VRASED_EVENT_LOG_EN

    localparam logic [IDX_W:0] LOG_FULL = (IDX_W + 1)'(LOG_DEPTH);

    logic [REC_W-1:0] r_log_mem [LOG_DEPTH];
    logic [IDX_W-1:0] r_wp;
    logic [IDX_W:0]   r_log_count;
    logic             r_log_ovf;
    logic [REC_W-1:0] r_rd_data;

    logic [IDX_W-1:0] w_wp_base;
    logic [IDX_W:0]   w_log_cnt_base;
    logic             w_log_full;
    logic [IDX_W-1:0] w_rd_addr;
    logic             w_rd_valid;

    assign w_wp_base      = i_clr_log ? '0 : r_wp;
    assign w_log_cnt_base = i_clr_log ? '0 : r_log_count;
    assign w_log_full     = (w_log_cnt_base == LOG_FULL);

    // Oldest entry sits log_count slots behind wp; when full, count mod depth is 0 so
    // the oldest entry is the one at wp itself.
    assign w_rd_addr  = r_wp - r_log_count[IDX_W-1:0] + i_rd_idx;
    assign w_rd_valid = ({1'b0, i_rd_idx} < r_log_count);

    // Log storage: one {pc, unmasked viol} record per event, written at the (cleared) wp.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_event) begin
            r_log_mem[w_wp_base] <= {i_pc, w_hit_vec};
        end
    end

    // Write pointer, fill level and overwrite flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp        <= '0;
            r_log_count <= '0;
            r_log_ovf   <= 1'b0;
        end else begin
            r_wp        <= w_wp_base;
            r_log_count <= w_log_cnt_base;
            r_log_ovf   <= i_clr_log ? 1'b0 : r_log_ovf;
            if (w_event) begin
                r_wp <= w_wp_base + IDX_W'(1);
                if (w_log_full) begin
                    r_log_ovf <= 1'b1;
                end else begin
                    r_log_count <= w_log_cnt_base + (IDX_W + 1)'(1);
                end
            end
        end
    end

    // Registered read port; uses pre-write pointers and contents, holds when not enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= w_rd_valid ? r_log_mem[w_rd_addr] : '0;
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_log_count = r_log_count;
    assign o_log_ovf   = r_log_ovf;

`else

    // No log storage: the read interface and pc have no function in this build.
    logic w_unused_log;
    assign w_unused_log = ^{i_re, i_rd_idx, i_pc};

    assign o_rd_data   = '0;
    assign o_log_count = '0;
    assign o_log_ovf   = 1'b0;

`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Bench for vrased_reset_ctrl: directed stimulus, a behavioural model of the spec's rules
// compared every cycle, plus hand-computed literal checks. Adapts to VRASED_EVENT_LOG_EN.
module tb_vrased_reset_ctrl;

    localparam int unsigned NS   = 6;
    localparam int unsigned HC   = 4;
    localparam int unsigned LD   = 8;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  viol;
    logic [5:0]  mask;
    logic [15:0] pc;
    logic        re;
    logic [2:0]  rd_idx;
    logic        clr;

    logic        o_reset;
    logic [5:0]  o_cause;
    logic [5:0]  o_first_cause;
    logic [1:0]  o_viol_cnt;
    logic [21:0] o_rd_data;
    logic [3:0]  o_log_count;
    logic        o_log_ovf;

    always #5 clk = ~clk;

    vrased_reset_ctrl #(
        .NUM_SRC     (NS),
        .HOLD_CYCLES (HC),
        .LOG_DEPTH   (LD),
        .CNT_W       (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_viol        (viol),
        .i_src_mask    (mask),
        .i_pc          (pc),
        .o_reset       (o_reset),
        .o_cause       (o_cause),
        .o_first_cause (o_first_cause),
        .o_viol_cnt    (o_viol_cnt),
        .i_re          (re),
        .i_rd_idx      (rd_idx),
        .o_rd_data     (o_rd_data),
        .o_log_count   (o_log_count),
        .o_log_ovf     (o_log_ovf),
        .i_clr_log     (clr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: "busy" means the MCU is being held in reset; m_left counts remaining
    // guaranteed cycles after the current one. Log is an ordered list of records.
    bit          m_busy;
    int          m_left;
    logic [5:0]  m_cause;
    logic [5:0]  m_first;
    int          m_cnt;
    logic [21:0] m_q[$];
    bit          m_ovf;
    logic [21:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rec(input logic [15:0] p, input logic [5:0] v);
`ifdef VRASED_EVENT_LOG_EN
        return 32'({p, v});
`else
        return 32'(0);
`endif
    endfunction

    task automatic model_step();
        logic [5:0] hv;
        bit         hit;
        hv  = viol & ~mask;
        hit = |hv;
        if (rst) begin
            m_busy = 0; m_left = 0; m_cause = '0; m_first = '0; m_cnt = 0;
            m_q.delete(); m_ovf = 0; m_rd = '0;
        end else begin
            if (re) m_rd = (int'(rd_idx) < m_q.size()) ? m_q[rd_idx] : '0;
            if (clr) begin
                m_cause = '0; m_first = '0; m_cnt = 0; m_q.delete(); m_ovf = 0;
            end
            m_cause = m_cause | hv;
            if (!m_busy && hit) begin
                if (m_cnt == 0) m_first = hv;
                if (m_cnt < CMAX) m_cnt++;
                m_q.push_back({pc, hv});
                if (m_q.size() > int'(LD)) begin
                    void'(m_q.pop_front());
                    m_ovf = 1;
                end
                m_busy = 1;
                m_left = int'(HC) - 1;
            end else if (m_busy) begin
                if (m_left > 0) m_left--;
                else if (!hit) m_busy = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("reset",       32'(o_reset),       32'(m_busy));
        chk("cause",       32'(o_cause),       32'(m_cause));
        chk("first_cause", 32'(o_first_cause), 32'(m_first));
        chk("viol_cnt",    32'(o_viol_cnt),    32'(m_cnt));
`ifdef VRASED_EVENT_LOG_EN
        chk("log_count",   32'(o_log_count),   32'(m_q.size()));
        chk("log_ovf",     32'(o_log_ovf),     32'(m_ovf));
        chk("rd_data",     32'(o_rd_data),     32'(m_rd));
`else
        chk("log_count",   32'(o_log_count),   32'(0));
        chk("log_ovf",     32'(o_log_ovf),     32'(0));
        chk("rd_data",     32'(o_rd_data),     32'(0));
`endif
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic run_count(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_reset) hi++;
        end
    endtask

    task automatic read_log(input logic [2:0] idx);
        re = 1'b1;
        rd_idx = idx;
        tick();
        re = 1'b0;
    endtask

    int h1, h2;

    initial begin
        rst = 1'b1; viol = '0; mask = '0; pc = '0; re = 1'b0; rd_idx = '0; clr = 1'b0;
        @(negedge clk);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_reset", 32'(o_reset), 32'(0));
        chk("rst_cnt", 32'(o_viol_cnt), 32'(0));
        chk("rst_log_count", 32'(o_log_count), 32'(0));
        rst = 1'b0;

        // Basic pulse
        pc = 16'h1234; viol = 6'b000100;
        tick();
        h1 = o_reset ? 1 : 0;
        viol = '0;
        run_count(9, h2);
        chk("basic_len", 32'(h1 + h2), 32'(4));
        chk("basic_cause", 32'(o_cause), 32'(6'b000100));
        chk("basic_cnt", 32'(o_viol_cnt), 32'(1));
        read_log(3'd0);
        chk("basic_log0", 32'(o_rd_data), rec(16'h1234, 6'b000100));
        tick();
        chk("basic_hold", 32'(o_rd_data), rec(16'h1234, 6'b000100));
        read_log(3'd3);
        chk("basic_invalid_idx", 32'(o_rd_data), 32'(0));

        // Masking and stretch
        rst = 1'b1; tick(); rst = 1'b0;
        mask = 6'b000001; viol = 6'b000001;
        run_count(10, h1);
        chk("mask_no_reset", 32'(h1), 32'(0));
        chk("mask_cnt", 32'(o_viol_cnt), 32'(0));
        chk("mask_cause", 32'(o_cause), 32'(0));
        viol = 6'b100000;
        run_count(7, h1);
        viol = '0;
        run_count(6, h2);
        chk("stretch_len", 32'(h1 + h2), 32'(7));
        chk("stretch_cnt", 32'(o_viol_cnt), 32'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        viol = 6'b100000; tick();
        viol = '0; tick();
        viol = 6'b010000; tick();
        viol = '0;
        run_count(6, h1);
        chk("hold_cause", 32'(o_cause), 32'(6'b110000));
        chk("hold_cnt", 32'(o_viol_cnt), 32'(1));
        chk("hold_first", 32'(o_first_cause), 32'(6'b100000));

        // Log wrap with counter saturation
        rst = 1'b1; tick(); rst = 1'b0;
        mask = '0;
        for (int i = 0; i < 10; i++) begin
            pc = 16'(32'h100 + i);
            viol = 6'(1 << (i % 6));
            tick();
            viol = '0;
            repeat (5) tick();
        end
        chk("sat_cnt", 32'(o_viol_cnt), 32'(3));
`ifdef VRASED_EVENT_LOG_EN
        chk("wrap_count", 32'(o_log_count), 32'(8));
        chk("wrap_ovf", 32'(o_log_ovf), 32'(1));
`endif
        read_log(3'd0);
        chk("wrap_idx0", 32'(o_rd_data), rec(16'h0102, 6'b000100));
        read_log(3'd7);
        chk("wrap_idx7", 32'(o_rd_data), rec(16'h0109, 6'b001000));

        // Clear coincident with an event
        pc = 16'h0abc; viol = 6'b011000; clr = 1'b1;
        tick();
        clr = 1'b0; viol = '0;
        chk("clr_cnt", 32'(o_viol_cnt), 32'(1));
        chk("clr_first", 32'(o_first_cause), 32'(6'b011000));
        chk("clr_cause", 32'(o_cause), 32'(6'b011000));
        chk("clr_ovf", 32'(o_log_ovf), 32'(0));
`ifdef VRASED_EVENT_LOG_EN
        chk("clr_count", 32'(o_log_count), 32'(1));
`endif
        repeat (5) tick();
        read_log(3'd0);
        chk("clr_log0", 32'(o_rd_data), rec(16'h0abc, 6'b011000));

        // Reset in the middle of HOLD
        pc = 16'h0777; viol = 6'b000001; tick();
        viol = '0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_reset", 32'(o_reset), 32'(0));
        chk("midrst_cause", 32'(o_cause), 32'(0));
        chk("midrst_cnt", 32'(o_viol_cnt), 32'(0));
        chk("midrst_rd", 32'(o_rd_data), 32'(0));
        // First event after reset, with a read of the same slot in the write cycle
        pc = 16'h0055; viol = 6'b000010; re = 1'b1; rd_idx = 3'd0;
        tick();
        h1 = o_reset ? 1 : 0;
        re = 1'b0; viol = '0;
        chk("post_rd_prewrite", 32'(o_rd_data), 32'(0));
        chk("post_cnt", 32'(o_viol_cnt), 32'(1));
        chk("post_first", 32'(o_first_cause), 32'(6'b000010));
        run_count(9, h2);
        chk("post_len", 32'(h1 + h2), 32'(4));
        read_log(3'd0);
        chk("post_log0", 32'(o_rd_data), rec(16'h0055, 6'b000010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vrased_reset_ctrl.md
# vrased_reset_ctrl

Parametrised violation aggregator and reset sequencer for the VRASED hardware monitors. It replaces the plain OR of the monitor reset lines (X_stack, AC, atomicity, dma_AC, dma_detect, dma_X_stack) with the following per-source features:
- masking
- a stretched, registered MCU reset pulse
- sticky cause capture
- a saturating violation counter
- an optional circular log of `{pc, cause}` records readable by the debug/attestation side

It sits between the monitor instances and the openMSP430 reset input.

## Interface
Parameters:
- `NUM_SRC`, 6, number of violation sources (bit i = monitor i)
- `HOLD_CYCLES`, 4, minimum cycles `reset` stays high per event (>=1)
- `LOG_DEPTH`, 8, log entries (power of two, >=2)
- `CNT_W`, 8, width of saturating violation counter

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `viol`  in  NUM_SRC  raw monitor reset requests, level
- `src_mask`  in  NUM_SRC  1 = ignore source i (static config)
- `pc`  in  16  current program counter
- `reset`  out  1  registered MCU reset
- `cause`  out  NUM_SRC  sticky OR of unmasked sources that triggered events
- `first_cause`  out  NUM_SRC  unmasked `viol` vector of the first event since `rst`/`clr_log`
- `viol_cnt`  out  CNT_W  events since `rst`/`clr_log`, saturating
- `re`  in  1  log read enable
- `rd_idx`  in  log2(LOG_DEPTH)  log index, 0 = oldest
- `rd_data`  out  16+NUM_SRC  `{pc, cause}` record
- `log_count`  out  log2(LOG_DEPTH)+1  valid entries
- `log_ovf`  out  1  sticky: an entry was overwritten
- `clr_log`  in  1  clears log, counter, `cause`, `first_cause`

## Operation
- `hit = |(viol & ~src_mask)`. An event is a cycle with `hit` while in state `IDLE`.
- FSM states:
  - **IDLE**: `reset`=0. On `hit` go to HOLD and load `hold_cnt = HOLD_CYCLES-1`.
  - **HOLD**: `reset`=1. Decrement `hold_cnt`. When it is 0, go to DRAIN.
  - **DRAIN**: `reset`=1. Stay while `hit`. When `hit`=0, go to IDLE (`reset` drops on the next edge).
- New `hit` activity during HOLD/DRAIN is not a new event. Those bits are still ORed into `cause`, but nothing is logged and nothing is counted.
- On each event:
  - `viol_cnt` increments unless already all-ones.
  - `cause |= viol & ~src_mask`.
  - `first_cause` is loaded only if `viol_cnt` was 0.
  - A log record `{pc, viol & ~src_mask}` is written, using `pc` sampled in the event cycle.
- Log behaviour:
  - Circular buffer with write pointer `wp` and `log_count`.
  - Not full: write at `wp`, increment `log_count`.
  - Full: overwrite the oldest entry and set `log_ovf`. `log_count` stays at `LOG_DEPTH`.
  - Read address is `(wp - log_count + rd_idx) mod LOG_DEPTH`.
  - `rd_idx >= log_count` returns all zeros.
- `clr_log`:
  - Zeroes `log_count`, `wp`, `log_ovf`, `viol_cnt`, `cause` and `first_cause`. The FSM is unaffected.
  - If an event occurs in the same cycle, the clear applies first and the event is then recorded. Result: `log_count`=1, `viol_cnt`=1, `cause` = `first_cause` = event vector.
- Masked sources never affect any state.

## Timing
- `rst` wins over everything. Next edge values:
  - FSM in IDLE.
  - `reset`=0, `cause`=0, `first_cause`=0, `viol_cnt`=0.
  - `log_count`=0, `log_ovf`=0, `rd_data`=0.
  - `wp`=0, `hold_cnt`=0.
- `rst` mid-HOLD/DRAIN aborts the pulse: `reset`=0 next cycle.
- Event latency: `viol` high at edge N gives `reset`=1 from edge N+1.
- A one-cycle `viol` gives exactly `HOLD_CYCLES` cycles of `reset`. `viol` held longer extends the pulse until `hit` has been low for one cycle.
- `cause`, `viol_cnt` and the log entry are visible at edge N+1.
- Read latency is 1 cycle: `rd_data` is registered on `re` and holds when `re`=0.
- A read in the same cycle as a log write returns pre-write contents.

## Configuration
- Macro `VRASED_EVENT_LOG_EN`.
- Defined: log RAM, `wp`, `log_count`, `log_ovf` and the read path are implemented as above.
- Undefined: no log storage. `rd_data`, `log_count` and `log_ovf` are tied to 0, and `re`/`rd_idx` are ignored. The FSM, `cause`, `first_cause` and `viol_cnt` are unchanged.

## Test plan
- **Basic pulse.** Default params; `viol`=6'b000100 for 1 cycle -> `reset` high exactly 4 cycles starting next edge; `cause`=6'b000100; `viol_cnt`=1; log[0]=`{pc, 6'b000100}`.
- **Masking and stretch.**
  - `src_mask`=6'b000001, `viol`=6'b000001 for 10 cycles -> no `reset`, counter 0.
  - Then `viol`=6'b100000 held 7 cycles -> `reset` high 7 cycles.
  - Later `viol`=6'b010000 pulsed at HOLD cycle 2 -> `cause`=6'b110000, `viol_cnt`=1.
- **Log wrap.** LOG_DEPTH=8, 10 separate events with pc=0x100..0x109 -> `log_count`=8, `log_ovf`=1, `rd_idx`=0 returns pc 0x102, `rd_idx`=7 returns 0x109, one cycle after `re`.
- **Saturation / clear collision.**
  - CNT_W=2, 5 events -> `viol_cnt`=3.
  - `clr_log` coincident with a 6th event -> `viol_cnt`=1, `log_count`=1, `first_cause` = 6th vector.
- **Reset mid-operation.** `rst` during HOLD cycle 2 -> all outputs 0 next edge; a subsequent event behaves as the first.
- **Configuration.** Build without `VRASED_EVENT_LOG_EN`, rerun the basic pulse test -> identical `reset`/`cause`/`viol_cnt`; `rd_data`=0, `log_count`=0.
